// File: rtl/alu_pkg.sv
// Shared types for the ALU flag unit: opcode and FSM state encodings, flag bundle.
package alu_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;

  typedef struct packed {
    logic c;
    logic z;
    logic n;
    logic v;
  } flags_t;

endpackage

// File: rtl/alu_flag_unit_if.sv
// Request/response bus of the ALU flag unit; master drives operations, slave returns results.
interface alu_flag_unit_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_ready;
  logic             c;
  logic             z;
  logic             n;
  logic             v;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out, out_valid, c, z, n, v
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out, out_valid, c, z, n, v
  );
endinterface

// File: rtl/alu_mul_serial.sv
// Unsigned serial shift-add multiplier: one partial product per cycle, WIDTH cycles per start.
module alu_mul_serial #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   sum_c;

  // Upper half accumulates the multiplicand when the multiplier LSB (product[0]) is set.
  always_comb begin
    sum_c = {1'b0, product[2*WIDTH-1:WIDTH]} + (product[0] ? {1'b0, mcand} : (WIDTH+1)'(0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= '0;
      product <= '0;
      cnt     <= '0;
      done    <= 1'b0;
    end else if (start) begin
      mcand   <= a;
      product <= {WIDTH'(0), b};
      cnt     <= CW'(WIDTH);
      done    <= 1'b0;
    end else if (cnt != '0) begin
      product <= {sum_c, product[WIDTH-1:1]};
      cnt     <= cnt - CW'(1);
      done    <= (cnt == CW'(1));
    end
  end

endmodule

// File: rtl/d_register.sv
// Generic enabled D register with synchronous active-high reset.
module D_Register #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/alu_flag_unit.sv
// ALU with registered result and C/Z/N/V flags behind a valid/ready handshake.
// Define ALU_FLAG_UNIT_MUL_EN to build the serial multiplier for op MUL; otherwise MUL returns 0 in one cycle.
module alu_flag_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  alu_flag_unit_if.slave bus
);

  state_e           state;
  state_e           state_next;
  op_e              op_c;
  logic             accept_c;
  logic             load_c;
  logic [WIDTH-1:0] result_c;
  flags_t           flags_c;
  logic [WIDTH:0]   sum_c;

  assign op_c     = op_e'(bus.op);
  assign accept_c = bus.in_valid && bus.in_ready;

`ifdef ALU_FLAG_UNIT_MUL_EN
  logic               mul_start_c;
  logic               mul_done;
  logic [2*WIDTH-1:0] product;

  assign mul_start_c = accept_c && (op_c == OP_MUL);

  alu_mul_serial #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start_c),
    .a       (bus.a),
    .b       (bus.b),
    .done    (mul_done),
    .product (product)
  );
`endif

  // State register; handshake outputs are registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
    end else begin
      state         <= state_next;
      bus.in_ready  <= (state_next == S_IDLE);
      bus.out_valid <= (state_next == S_DONE);
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept_c) begin
`ifdef ALU_FLAG_UNIT_MUL_EN
          state_next = (op_c == OP_MUL) ? S_BUSY : S_DONE;
`else
          state_next = S_DONE;
`endif
        end
      end
      S_BUSY: begin
`ifdef ALU_FLAG_UNIT_MUL_EN
        if (mul_done) begin
          state_next = S_DONE;
        end
`else
        state_next = S_IDLE;
`endif
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic: result and flags to be captured on entry to DONE.
  always_comb begin
    load_c   = (state_next == S_DONE) && (state != S_DONE);
    result_c = '0;
    flags_c  = '0;
    sum_c    = '0;
    if (state == S_IDLE) begin
      case (op_c)
        OP_ADD: begin
          sum_c     = {1'b0, bus.a} + {1'b0, bus.b};
          result_c  = sum_c[WIDTH-1:0];
          flags_c.c = sum_c[WIDTH];
          flags_c.v = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum_c[WIDTH-1] != bus.a[WIDTH-1]);
        end
        OP_SUB: begin
          sum_c     = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH+1)'(1);
          result_c  = sum_c[WIDTH-1:0];
          flags_c.c = sum_c[WIDTH];
          flags_c.v = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sum_c[WIDTH-1] != bus.a[WIDTH-1]);
        end
        OP_AND: result_c = bus.a & bus.b;
        OP_OR:  result_c = bus.a | bus.b;
        OP_XOR: result_c = bus.a ^ bus.b;
        OP_SHL: begin
          result_c  = {bus.a[WIDTH-2:0], 1'b0};
          flags_c.c = bus.a[WIDTH-1];
        end
        OP_SHR: begin
          result_c  = {1'b0, bus.a[WIDTH-1:1]};
          flags_c.c = bus.a[0];
        end
        default: result_c = '0;
      endcase
    end
`ifdef ALU_FLAG_UNIT_MUL_EN
    else if (state == S_BUSY) begin
      result_c  = product[WIDTH-1:0];
      flags_c.c = |product[2*WIDTH-1:WIDTH];
      flags_c.v = |product[2*WIDTH-1:WIDTH];
    end
`endif
    flags_c.z = (result_c == '0);
    flags_c.n = result_c[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out <= '0;
    end else if (load_c) begin
      bus.out <= result_c;
    end
  end

  D_Register #(.W(1)) u_flag_c (.clk(clk), .rst(rst), .en(load_c), .d(flags_c.c), .q(bus.c));
  D_Register #(.W(1)) u_flag_z (.clk(clk), .rst(rst), .en(load_c), .d(flags_c.z), .q(bus.z));
  D_Register #(.W(1)) u_flag_n (.clk(clk), .rst(rst), .en(load_c), .d(flags_c.n), .q(bus.n));
  D_Register #(.W(1)) u_flag_v (.clk(clk), .rst(rst), .en(load_c), .d(flags_c.v), .q(bus.v));

endmodule

// File: doc/alu_flag_unit.md
ALU_FLAG_UNIT -- requirements
Module: alu_flag_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  operation request present.
REQ-005 SHALL have port in_ready  output  1  unit can accept an operation.
REQ-006 SHALL have port op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
REQ-007 SHALL have ports a, b  input  WIDTH  operands.
REQ-008 SHALL have port out  output  WIDTH  registered result.
REQ-009 SHALL have port out_valid  output  1  result and flags valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have ports c, z, n, v  output  1 each  registered carry, zero, negative, overflow flags.

Function
REQ-012 SHALL use FSM states IDLE, BUSY, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-013 SHALL capture op, a, b when in_valid && in_ready.
REQ-014 SHALL, for ops 000-110, go IDLE->DONE: out_valid high exactly 1 cycle after accept.
REQ-015 SHALL, for MUL, go IDLE->BUSY, run serial shift-add for WIDTH cycles, then BUSY->DONE: out_valid high WIDTH+1 cycles after accept.
REQ-016 SHALL go DONE->IDLE on out_ready; out and flags SHALL hold stable while out_valid && !out_ready.
REQ-017 SHALL ignore in_valid while state != IDLE (no queuing, no overwrite).
REQ-018 ADD: out = a+b mod 2^WIDTH, c = carry-out, v = signed overflow.
REQ-019 SUB: out = a+~b+1, c = carry-out (1 = no borrow), v = signed overflow.
REQ-020 AND/OR/XOR: c=0, v=0.
REQ-021 SHL: out = a<<1, c = a[WIDTH-1]; SHR (logical): out = a>>1, c = a[0]; v=0 for both.
REQ-022 MUL: unsigned, out = low WIDTH bits of 2*WIDTH product, c = v = (upper WIDTH bits != 0).
REQ-023 For every op: z = (out==0), n = out[WIDTH-1]; flags update only on entry to DONE, never in IDLE or BUSY.
REQ-024 SHALL ignore b for SHL/SHR.

Reset
REQ-025 SHALL, with rst high at a clock edge, force state IDLE, out=0, c=z=n=v=0, clear multiplier state, including mid-MUL or mid-DONE.
REQ-026 SHALL present in_ready=1, out_valid=0 on the first cycle after rst deasserts.

Configuration
REQ-027 Macro ALU_FLAG_UNIT_MUL_EN, when defined, SHALL compile in the serial multiplier and BUSY behaviour per REQ-015/022.
REQ-028 Without ALU_FLAG_UNIT_MUL_EN, op 111 SHALL complete in 1 cycle like REQ-014 with out=0, c=0, z=1, n=0, v=0; BUSY SHALL be unreachable.

Structure
REQ-029 Package alu_pkg SHALL hold the op enum (3-bit) and FSM state enum.
REQ-030 Multiplier SHALL be sub-module alu_mul_serial (start, a, b -> done, product[2*WIDTH-1:0]), instantiated only under the macro.
REQ-031 Flag registers SHALL reuse the codebase's D_Register building block, 1 bit each, enabled on DONE entry.

Verification (WIDTH=8)
REQ-032 ADD a=0xFF b=0x01 -> out=0x00, c=1 z=1 n=0 v=0, out_valid 1 cycle after accept.
REQ-033 SUB a=0x80 b=0x01 -> out=0x7F, c=1 z=0 n=0 v=1; SUB a=0x00 b=0x01 -> out=0xFF, c=0 n=1 v=0.
REQ-034 MUL (macro on) a=0x0F b=0x03 -> out=0x2D c=0 v=0 after 9 cycles; a=0x10 b=0x10 -> out=0x00 c=1 v=1 z=1; macro off -> out=0, z=1 after 1 cycle.
REQ-035 SHR a=0x01 -> out=0x00 c=1 z=1; SHL a=0x81 -> out=0x02 c=1 n=0.
REQ-036 ADD 0x01+0x02 with out_ready low 5 cycles -> out=0x03 and flags stable, in_ready=0, second in_valid ignored; out_ready high -> IDLE next cycle.
REQ-037 rst high 3 cycles after MUL accept -> next cycle out=0, flags 0, out_valid=0, in_ready=1; subsequent ADD 0x02+0x02 -> 0x04.
